// File: rtl/main_osc_stab_timer_if.sv
// ============================================================================
// Module  : main_osc_stab_timer_if
// Brief   : Control and status bundle between CSC and the main-oscillator
//           stabilization timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface main_osc_stab_timer_if #(
  parameter int CNT_W = 18
) ();
  logic             OSCSEL;
  logic             MSTOP;
  logic             OSCOUTM;
  logic [2:0]       OSTS;
  logic [7:0]       OSTC;
  logic             MSTAB;
  logic [CNT_W-1:0] CNT;

  modport master (
    output OSCSEL, MSTOP, OSCOUTM, OSTS,
    input  OSTC, MSTAB, CNT
  );

  modport slave (
    input  OSCSEL, MSTOP, OSCOUTM, OSTS,
    output OSTC, MSTAB, CNT
  );
endinterface

`default_nettype wire

// File: rtl/main_osc_stab_timer.sv
// ============================================================================
// Module  : main_osc_stab_timer
// Brief   : Counts synchronized OSCOUTM rising edges after oscillator enable
//           and publishes thermometer status OSTC plus stable flag MSTAB.
//           Optional macro MAIN_OSC_STAB_FASTSIM_EN divides all compare
//           values by 64 for fast bring-up simulation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_osc_stab_timer #(
  parameter int CNT_W       = 18,
  parameter int SYNC_STAGES = 2
) (
  input wire                    BASECK,
  input wire                    RESET,
  main_osc_stab_timer_if.slave  bus
);

`ifdef MAIN_OSC_STAB_FASTSIM_EN
  localparam int c_SHIFT = 6;
`else
  localparam int c_SHIFT = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_STABLE = 2'd2
  } state_t;

  // Compare value for OSTS index idx, capped at the saturated count so the
  // largest thresholds remain reachable when CNT_W is too narrow for them.
  function automatic logic [31:0] f_limit(input int idx);
    int          e;
    logic [31:0] v;
    logic [31:0] m;
    case (idx)
      0:       e = 8;
      1:       e = 9;
      2:       e = 10;
      3:       e = 11;
      4:       e = 13;
      5:       e = 15;
      6:       e = 17;
      default: e = 18;
    endcase
    v = 32'd1 << (e - c_SHIFT);
    m = (32'd1 << CNT_W) - 32'd1;
    return (v > m) ? m : v;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_hist;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [7:0]           r_ostc;
  logic [7:0]           w_ostc_nxt;
  logic                 r_mstab;
  logic                 w_mstab_nxt;
  logic                 w_run;
  logic                 w_edge;
  logic                 w_cnt_sat;
  logic [31:0]          w_cnt_ext;
  logic [7:0]           w_ge;
  logic [7:0]           w_therm;

  assign w_run     = bus.OSCSEL & ~bus.MSTOP;
  assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_cnt_sat = &r_cnt;
  assign w_cnt_ext = 32'(r_cnt);

  // w_ge is indexed by OSTS; OSTC carries the same compares MSB first.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
      assign w_ge[gi]      = (w_cnt_ext >= f_limit(gi));
      assign w_therm[7-gi] = w_ge[gi];
    end
  endgenerate

  always_ff @(posedge BASECK) begin
    if (RESET) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.OSCOUTM};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge BASECK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ostc  <= 8'h00;
      r_mstab <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ostc  <= w_ostc_nxt;
      r_mstab <= w_mstab_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ostc_nxt  = r_ostc;
    w_mstab_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_ostc_nxt = 8'h00;
        w_state_nxt = S_COUNT;
      end
      S_COUNT, S_STABLE: begin
        if (w_edge && !w_cnt_sat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        w_ostc_nxt  = r_ostc | w_therm;
        // Live OSTS: raising it above CNT drops back to COUNT without a clear.
        w_state_nxt = w_ge[bus.OSTS] ? S_STABLE : S_COUNT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (!w_run) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_ostc_nxt  = 8'h00;
    end
    w_mstab_nxt = (w_state_nxt == S_STABLE);
  end

  assign bus.CNT   = r_cnt;
  assign bus.OSTC  = r_ostc;
  assign bus.MSTAB = r_mstab;

endmodule

`default_nettype wire
